// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1 -- 8N1 UART receiver (8 data bits, no parity, 1 stop bit, LSB first).
//
// It takes the serial line from the matching 8N1 transmitter and returns parallel
// bytes. Bit timing comes from CLKS_PER_BIT system clocks per bit. The start bit is
// checked at its midpoint, and each later bit is sampled one full bit period after
// the previous sample.
//
// Ports:
//   clk          system clock; all logic uses the rising edge
//   rst_n        synchronous active-low reset
//   uart_rx      asynchronous serial input, idle high
//   rx_data      received byte; stable while rx_valid=1
//   rx_valid     rx_data holds a byte that has not been consumed
//   rx_ready     consumer takes the byte on an edge where rx_valid & rx_ready
//   busy         receiver is inside a frame (any state other than IDLE)
//   framing_err  one-cycle pulse when the stop bit is sampled as 0
//   overrun      one-cycle pulse when a frame completes while rx_data is still full
//                (the new byte is dropped)

module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       framing_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             rx_s_q, rx_s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             framing_err_q, framing_err_d;
    logic             overrun_q, overrun_d;

    // Two-flop synchronizer. Every decision below uses rx_s_q only.
    always_comb begin
        sync1_d = uart_rx;
        rx_s_d  = sync1_q;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        framing_err_d = 1'b0;
        overrun_d     = 1'b0;

        // A consumed byte frees the register. A byte loaded in STOP on the same edge
        // overrides this below, so rx_valid stays high with the new data.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        // The line went high before mid-start-bit: a glitch, not a frame.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        // Return to IDLE at mid-stop-bit so a back-to-back start edge is caught.
                        state_d = S_IDLE;
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        framing_err_d = 1'b1;
                        state_d       = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_BREAK: begin
                // Stay here while the line is held low, so a break is not decoded
                // as a stream of 0x00 frames.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q       <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            rx_s_q        <= rx_s_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1 -- directed testbench for uart_rx_8n1 with CLKS_PER_BIT=16.
// Frames are driven with the 8N1 transmitter timing: 16 clocks per bit, start bit
// low, data bits LSB first, then the stop bit.

module tb_uart_rx_8n1;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       framing_err;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;

    // Pulse and handshake monitors, sampled on the falling edge.
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         both_cnt = 0;
    int         acc_cnt  = 0;
    logic [7:0] acc_bytes [0:63];

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .framing_err(framing_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (framing_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (framing_err && overrun) both_cnt++;
        if (rx_valid && rx_ready && acc_cnt < 64) begin
            acc_bytes[acc_cnt] = rx_data;
            acc_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop_bit;
        tick(CPB);
    endtask

    int fe0, ov0, acc0, busy_cycles;

    initial begin
        rst_n    = 1'b0;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Reset state
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_framing_err", 32'(framing_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        tick(5);

        // 0xA5 received with rx_ready=0; the byte is held until rx_ready is pulsed
        fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_cnt;
        send_frame(8'hA5, 1'b1);
        tick(2);
        check("a5_rx_valid", 32'(rx_valid), 32'h1);
        check("a5_rx_data", 32'(rx_data), 32'hA5);
        check("a5_busy_idle", 32'(busy), 32'h0);
        tick(30);
        check("a5_still_valid", 32'(rx_valid), 32'h1);
        check("a5_still_data", 32'(rx_data), 32'hA5);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("a5_valid_dropped", 32'(rx_valid), 32'h0);
        check("a5_busy_after", 32'(busy), 32'h0);
        check("a5_accepted_count", 32'(acc_cnt - acc0), 32'd1);
        check("a5_accepted_byte", 32'(acc_bytes[acc0]), 32'hA5);
        check("a5_no_errors", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
        tick(5);

        // A 5-clock low glitch is rejected at mid-start-bit
        fe0 = fe_cnt;
        busy_cycles = 0;
        uart_rx = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i == 5) uart_rx = 1'b1;
            tick(1);
            if (busy) busy_cycles++;
        end
        check("glitch_busy_pulsed", 32'(busy_cycles >= 1 && busy_cycles <= HALF + 3), 32'h1);
        check("glitch_busy_end", 32'(busy), 32'h0);
        check("glitch_no_valid", 32'(rx_valid), 32'h0);
        check("glitch_no_framing", 32'(fe_cnt - fe0), 32'd0);

        // 0x3C with stop bit 0, then the line is held low (break)
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h3C, 1'b0);
        tick(40);
        check("break_framing_once", 32'(fe_cnt - fe0), 32'd1);
        check("break_no_valid", 32'(rx_valid), 32'h0);
        check("break_busy_held", 32'(busy), 32'h1);
        check("break_no_overrun", 32'(ov_cnt - ov0), 32'd0);
        uart_rx = 1'b1;
        tick(5);
        check("break_busy_released", 32'(busy), 32'h0);
        check("break_framing_total", 32'(fe_cnt - fe0), 32'd1);
        tick(5);

        // 0x11 then 0x22 with rx_ready=0: the second byte overruns and is dropped
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(3);
        check("ovr_rx_data", 32'(rx_data), 32'h11);
        check("ovr_rx_valid", 32'(rx_valid), 32'h1);
        check("ovr_pulse_once", 32'(ov_cnt - ov0), 32'd1);
        check("ovr_no_framing", 32'(fe_cnt - fe0), 32'd0);
        rx_ready = 1'b1;
        tick(1);
        check("ovr_drained", 32'(rx_valid), 32'h0);

        // Back-to-back 0x00, 0xFF, 0x5A with rx_ready held at 1
        fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_cnt;
        tick(4);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h5A, 1'b1);
        tick(20);
        check("b2b_count", 32'(acc_cnt - acc0), 32'd3);
        check("b2b_byte0", 32'(acc_bytes[acc0]), 32'h00);
        check("b2b_byte1", 32'(acc_bytes[acc0 + 1]), 32'hFF);
        check("b2b_byte2", 32'(acc_bytes[acc0 + 2]), 32'h5A);
        check("b2b_no_errors", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
        check("b2b_valid_consumed", 32'(rx_valid), 32'h0);

        // Reset during bit 4 of a frame, then receive 0x81
        rx_ready = 1'b0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        uart_rx = 1'b0;
        tick(CPB * 5);
        uart_rx = 1'b1;
        tick(HALF);
        check("midrst_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("midrst_rx_data", 32'(rx_data), 32'h00);
        check("midrst_rx_valid", 32'(rx_valid), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_framing_err", 32'(framing_err), 32'h0);
        check("midrst_overrun", 32'(overrun), 32'h0);
        tick(CPB * 6);
        check("midrst_quiet_after", 32'((fe_cnt - fe0) + (ov_cnt - ov0) + int'(rx_valid)), 32'd0);
        send_frame(8'h81, 1'b1);
        tick(2);
        check("post_rst_rx_data", 32'(rx_data), 32'h81);
        check("post_rst_rx_valid", 32'(rx_valid), 32'h1);
        check("post_rst_no_errors", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

        check("errors_never_together", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
